// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch front
//               end (queue entry layout, default depth, address helper).
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // One buffered fetch: the word and the address it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam int          FQ_DEPTH_DEFAULT = 4;

  // Instruction fetches are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Control, instruction-memory and IF/ID handshake signals of
//               the fetch front end. master = fetch_queue, slave = its
//               environment (ID stage plus instruction memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if;
  logic        start_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;

  modport master (
    input  start_i, redirect_i, redirect_pc_i,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
  );

  modport slave (
    output start_i, redirect_i, redirect_pc_i,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Small synchronous FIFO with push/pop/clear, occupancy count
//               and a head output read straight from storage. DEPTH must be
//               a power of two so the pointers wrap naturally. The caller
//               never pushes when full nor pops when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [63:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  T                           i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output T                           o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  // Storage; zeroed on reset so the head reads 0 while empty after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; clear drops every entry at once
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Instruction fetch front end. Owns the fetch PC, issues word
//               requests over req/gnt/rvalid, buffers returned words with
//               their PCs and feeds the IF/ID buffer. A redirect flushes the
//               queue and marks all in-flight fetches for discard.
//               Optional feature: FETCH_QUEUE_BYPASS_EN - a response arriving
//               at an empty queue is presented combinationally the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = CW + 2;

  // r_outst counts only live requests (issued since the last redirect);
  // requests made stale by a redirect are tracked in r_disc instead.
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_disc;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_data;
  logic [SW-1:0] w_inflight;
  logic [31:0]   w_oldest_pc;
  logic          w_req;
  logic          w_fire;
  logic          w_resp_live;
  logic          w_push;
  logic          w_pop;

  // Credit: queued words plus every in-flight request must fit in DEPTH
  assign w_inflight  = SW'(w_count) + SW'(r_outst) + SW'(r_disc);
  assign w_req       = bus.start_i & ~bus.redirect_i & (w_inflight < SW'(DEPTH));
  assign w_fire      = w_req & bus.imem_gnt_i;
  assign w_resp_live = bus.imem_rvalid_i & (r_disc == '0);

  // Live requests are consecutive words ending just below fetch_pc
  assign w_oldest_pc = r_fetch_pc - (32'(r_outst) << 2);
  assign w_push_data = '{pc: w_oldest_pc, inst: bus.imem_rdata_i};
  assign w_pop       = (w_count != '0) & bus.inst_ready_i & ~bus.redirect_i;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass         = (w_count == '0) & w_resp_live & ~bus.redirect_i;
  assign w_push           = w_resp_live & ~bus.redirect_i & ~(w_bypass & bus.inst_ready_i);
  assign bus.inst_valid_o = (w_count != '0) | w_bypass;
  assign bus.inst_o       = w_bypass ? bus.imem_rdata_i : w_head.inst;
  assign bus.pc_o         = w_bypass ? w_oldest_pc      : w_head.pc;
`else
  assign w_push           = w_resp_live & ~bus.redirect_i;
  assign bus.inst_valid_o = (w_count != '0);
  assign bus.inst_o       = w_head.inst;
  assign bus.pc_o         = w_head.pc;
`endif

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_fetch_pc;

  // Fetch PC plus live/discard request bookkeeping; redirect wins over all
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_outst    <= '0;
      r_disc     <= '0;
    end else if (bus.redirect_i) begin
      r_fetch_pc <= word_align(bus.redirect_pc_i);
      r_outst    <= '0;
      r_disc     <= r_disc + r_outst - CW'(bus.imem_rvalid_i);
    end else begin
      if (w_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
      r_outst <= r_outst + CW'(w_fire) - CW'(w_resp_live);
      r_disc  <= r_disc - CW'(bus.imem_rvalid_i & (r_disc != '0));
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_queue (
    .clk         (clk_i),
    .rst         (rst_i),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_clear     (bus.redirect_i),
    .o_count     (w_count),
    .o_head      (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue. A transaction-level
//               model (queue of words, list of in-flight requests tagged
//               with a redirect epoch) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  fetch_entry_t q[$];
  mreq_t        pend[$];
  int           epoch    = 0;
  int           cyc      = 0;
  int           last_due = 0;
  logic [31:0]  exp_fetch = RESET_PC;
  logic [31:0]  data_xor  = 32'h0;
  int           n_chk  = 0;
  int           n_fail = 0;

  logic         start_v    = 1'b0;
  logic         redir_v    = 1'b0;
  logic         ready_v    = 1'b1;
  logic [31:0]  redir_pc_v = 32'h0;
  int           gnt_pct = 100;
  int           lat_lo  = 1;
  int           lat_hi  = 1;
  bit           chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    bus.start_i       = start_v;
    bus.redirect_i    = redir_v;
    bus.redirect_pc_i = redir_pc_v;
    bus.inst_ready_i  = ready_v;
  endtask

  // Apply the next cycle's control inputs without any memory activity
  task automatic peek();
    drive_inputs();
    bus.imem_rvalid_i = 1'b0;
    bus.imem_gnt_i    = 1'b0;
    #1;
  endtask

  // One clock cycle: drive, predict and compare, then advance the model
  task automatic tick();
    bit          rv, live, byp, vis, take, fire, exp_req;
    mreq_t       head_req;
    logic [31:0] vis_pc, vis_inst;
    int          d;
    drive_inputs();
    rv = (pend.size() > 0) && (pend[0].due <= cyc);
    if (rv) head_req = pend[0];
    bus.imem_rvalid_i = rv;
    bus.imem_rdata_i  = rv ? (head_req.addr ^ data_xor) : $urandom;
    live = rv && (head_req.epoch == epoch) && !redir_v;
    #1;
    bus.imem_gnt_i = bus.imem_req_o && (int'($urandom_range(99)) < gnt_pct);
    #1;
    fire    = bus.imem_req_o && bus.imem_gnt_i;
    exp_req = start_v && !redir_v && ((q.size() + pend.size()) < DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (q.size() == 0) && live;
`else
    byp = 1'b0;
`endif
    vis = (q.size() > 0) || byp;
    if (q.size() > 0) begin
      vis_pc   = q[0].pc;
      vis_inst = q[0].inst;
    end else begin
      vis_pc   = head_req.addr;
      vis_inst = head_req.addr ^ data_xor;
    end
    take = vis && ready_v;
    if (chk_en) begin
      check("imem_req", {31'b0, bus.imem_req_o}, {31'b0, exp_req});
      if (exp_req) check("imem_addr", bus.imem_addr_o, exp_fetch);
      check("inst_valid", {31'b0, bus.inst_valid_o}, {31'b0, vis});
      if (vis) begin
        check("pc", bus.pc_o, vis_pc);
        check("inst", bus.inst_o, vis_inst);
      end
    end
    @(posedge clk);
    if (rst_i) begin
      q.delete();
      pend.delete();
      exp_fetch = RESET_PC;
      epoch++;
      last_due = cyc;
    end else begin
      if (rv) void'(pend.pop_front());
      if (redir_v) begin
        q.delete();
        epoch++;
        exp_fetch = {redir_pc_v[31:2], 2'b00};
      end else begin
        if (take && q.size() > 0) void'(q.pop_front());
        if (live && !(byp && ready_v))
          q.push_back('{pc: head_req.addr, inst: head_req.addr ^ data_xor});
        if (fire) begin
          d = cyc + int'($urandom_range(lat_hi, lat_lo));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pend.push_back('{addr: exp_fetch, epoch: epoch, due: d});
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    bus.start_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.inst_ready_i  = 1'b1;
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    tick();
    rst_i  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    peek();
    check("rst_valid", {31'b0, bus.inst_valid_o}, 32'h0);
    check("rst_req", {31'b0, bus.imem_req_o}, 32'h0);
    check("rst_addr", bus.imem_addr_o, RESET_PC);
    check("rst_pc", bus.pc_o, 32'h0);
    check("rst_inst", bus.inst_o, 32'h0);

    // Streaming from single-cycle memory returning the address as data
    start_v = 1'b1;
    ready_v = 1'b1;
    tick();
    tick();
`ifndef FETCH_QUEUE_BYPASS_EN
    for (int k = 0; k < 8; k++) begin
      check("seq_valid", {31'b0, bus.inst_valid_o}, 32'h1);
      check("seq_pc", bus.pc_o, 32'(k * 4));
      check("seq_inst", bus.inst_o, 32'(k * 4));
      tick();
    end
`else
    repeat (8) tick();
`endif

    // Stall for six cycles: queue fills, requests stop, head holds
    ready_v = 1'b0;
    repeat (6) tick();
    peek();
    check("stall_req", {31'b0, bus.imem_req_o}, 32'h0);
    check("stall_valid", {31'b0, bus.inst_valid_o}, 32'h1);
`ifndef FETCH_QUEUE_BYPASS_EN
    check("stall_pc", bus.pc_o, 32'h20);
    ready_v = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check("resume_pc", bus.pc_o, 32'h20 + 32'(k * 4));
      tick();
    end
`else
    ready_v = 1'b1;
    repeat (6) tick();
`endif

    // Three-cycle memory, two fetches in flight, then redirect to 0x100
    lat_lo = 3;
    lat_hi = 3;
    repeat (8) tick();
    start_v = 1'b0;
    for (int k = 0; k < 10 && pend.size() != 2; k++) tick();
    check("two_outstanding", pend.size(), 32'd2);
    start_v    = 1'b1;
    redir_v    = 1'b1;
    redir_pc_v = 32'h100;
    tick();
    redir_v = 1'b0;
    peek();
    check("redir_valid", {31'b0, bus.inst_valid_o}, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.inst_valid_o) found = 1'b1;
      else tick();
    end
    check("redir_seen", {31'b0, found}, 32'h1);
    if (found) check("redir_pc", bus.pc_o, 32'h100);

    // Misaligned target is forced to a word address
    lat_lo = 1;
    lat_hi = 1;
    repeat (6) tick();
    redir_v    = 1'b1;
    redir_pc_v = 32'h103;
    tick();
    redir_v = 1'b0;
    peek();
    check("align_req", {31'b0, bus.imem_req_o}, 32'h1);
    check("align_addr", bus.imem_addr_o, 32'h100);
    repeat (4) tick();

    // Redirect in the same cycle as a response and a ready head
    for (int k = 0; k < 10 && !(pend.size() > 0 && pend[0].due <= cyc); k++) tick();
    check("rv_pending", {31'b0, (pend.size() > 0 && pend[0].due <= cyc)}, 32'h1);
    redir_v    = 1'b1;
    redir_pc_v = 32'h200;
    tick();
    redir_v = 1'b0;
    peek();
    check("rvredir_valid", {31'b0, bus.inst_valid_o}, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.inst_valid_o) found = 1'b1;
      else tick();
    end
    check("rvredir_seen", {31'b0, found}, 32'h1);
    if (found) check("rvredir_pc", bus.pc_o, 32'h200);

    // Reset mid-stream with a full queue
    ready_v = 1'b0;
    repeat (8) tick();
    rst_i = 1'b1;
    tick();
    rst_i   = 1'b0;
    start_v = 1'b0;
    peek();
    check("mrst_valid", {31'b0, bus.inst_valid_o}, 32'h0);
    check("mrst_req", {31'b0, bus.imem_req_o}, 32'h0);
    check("mrst_pc", bus.pc_o, 32'h0);
    check("mrst_inst", bus.inst_o, 32'h0);
    check("mrst_addr", bus.imem_addr_o, RESET_PC);
    data_xor = 32'hA5A5_A5A5;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        lat_lo  = 1;
        lat_hi  = 1 + int'($urandom_range(3));
        gnt_pct = 50 + int'($urandom_range(50));
      end
      start_v    = ($urandom_range(9) != 0);
      ready_v    = ($urandom_range(9) < 7);
      redir_v    = ($urandom_range(29) == 0);
      redir_pc_v = $urandom;
      rst_i      = ($urandom_range(499) == 0);
      tick();
    end
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
